// File: rtl/note_player_periodic.sv
// rtl/note_player_periodic.sv - square-wave note player with per-phase half-period counts and period count
// Optional rest feature: define NOTE_PLAYER_REST_EN to play a captured half_high of 0 as silence.
module note_player_periodic #(
  parameter int CNT_W = 16,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_high,
  input  logic [CNT_W-1:0] half_low,
  input  logic [DUR_W-1:0] duration,
  output logic [3:0]       state,
  output logic             note,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE      = 4'b0000,
    LOAD_HIGH = 4'b1000,
    WAIT_HIGH = 4'b0100,
    LOAD_LOW  = 4'b0010,
    WAIT_LOW  = 4'b0001
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] hh_q;
  logic [CNT_W-1:0] hl_q;
  logic [CNT_W-1:0] cnt;
  logic [DUR_W-1:0] per_cnt;
  logic             rest_cur;
  logic             rest_new;

  // rest_new looks at the live input because the capture happens on the same edge
`ifdef NOTE_PLAYER_REST_EN
  assign rest_cur = (hh_q == '0);
  assign rest_new = (half_high == '0);
`else
  assign rest_cur = 1'b0;
  assign rest_new = 1'b0;
`endif

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hh_q    <= '0;
      hl_q    <= '0;
      cnt     <= '0;
      per_cnt <= '0;
      note    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state_q != IDLE)) begin
        state_q <= IDLE;
        note    <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              hh_q    <= half_high;
              hl_q    <= half_low;
              per_cnt <= duration;
              if (duration != '0) begin
                state_q <= LOAD_HIGH;
                note    <= !rest_new;
                busy    <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          LOAD_HIGH: begin
            cnt     <= hh_q;
            state_q <= WAIT_HIGH;
          end
          WAIT_HIGH: begin
            if (cnt == '0) begin
              state_q <= LOAD_LOW;
              note    <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          LOAD_LOW: begin
            cnt     <= hl_q;
            state_q <= WAIT_LOW;
          end
          WAIT_LOW: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              per_cnt <= per_cnt - DUR_W'(1);
              // per_cnt is the count before this decrement, so 1 means the last period just ended
              if (per_cnt != DUR_W'(1)) begin
                state_q <= LOAD_HIGH;
                note    <= !rest_cur;
              end else begin
                state_q <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            note    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_player_periodic.sv
// tb/tb_note_player_periodic.sv - directed and randomized checks of note_player_periodic against a waveform model
module tb_note_player_periodic;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] half_high;
  logic [15:0] half_low;
  logic [15:0] duration;
  logic [3:0]  state;
  logic        note;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  note_player_periodic #(.CNT_W(16), .DUR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .half_high (half_high),
    .half_low  (half_low),
    .duration  (duration),
    .state     (state),
    .note      (note),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check_state({tag, "_state"}, state, 4'b0000);
    check_bit({tag, "_note"}, note, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, exp_done);
  endtask

  task automatic scramble;
    half_high = 16'($urandom);
    half_low  = 16'($urandom);
    duration  = 16'($urandom);
  endtask

  task automatic begin_note(input int hh, input int hl, input int dur);
    half_high = 16'(hh);
    half_low  = 16'(hl);
    duration  = 16'(dur);
    start     = 1'b1;
    tick();
    start = 1'b0;
    scramble();
  endtask

  // Model: each period is hh+2 high cycles then hl+2 low cycles, then one IDLE cycle with done.
  // Called one cycle after acceptance; returns in the done cycle without advancing.
  task automatic run_note(input int hh, input int hl, input int dur, input string tag);
    logic hi;
    hi = 1'b1;
`ifdef NOTE_PLAYER_REST_EN
    if (hh == 0) hi = 1'b0;
`endif
    for (int p = 0; p < dur; p++) begin
      for (int c = 0; c < hh + 2; c++) begin
        check_bit({tag, "_hi_note"}, note, hi);
        check_bit({tag, "_hi_busy"}, busy, 1'b1);
        check_bit({tag, "_hi_done"}, done, 1'b0);
        if (c == 0) check_state({tag, "_load_high"}, state, 4'b1000);
        if (c == 1) check_state({tag, "_wait_high"}, state, 4'b0100);
        tick();
      end
      for (int c = 0; c < hl + 2; c++) begin
        check_bit({tag, "_lo_note"}, note, 1'b0);
        check_bit({tag, "_lo_busy"}, busy, 1'b1);
        check_bit({tag, "_lo_done"}, done, 1'b0);
        if (c == 0) check_state({tag, "_load_low"}, state, 4'b0010);
        if (c == 1) check_state({tag, "_wait_low"}, state, 4'b0001);
        tick();
      end
    end
    check_idle({tag, "_done"}, 1'b1);
  endtask

  task automatic end_idle(input string tag);
    tick();
    check_idle(tag, 1'b0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    half_high = '0;
    half_low  = '0;
    duration  = '0;
    tick();
    tick();
    check_idle("reset", 1'b0);
    rst = 1'b1;
    tick();
    check_idle("post_reset", 1'b0);

    begin_note(2, 1, 2);
    run_note(2, 1, 2, "basic");
    end_idle("basic_after");

    begin_note(3, 3, 0);
    run_note(3, 3, 0, "dur0");
    end_idle("dur0_after");

    begin_note(3, 2, 2);
    tick();
    tick();
    check_state("stop_pre", state, 4'b0100);
    stop = 1'b1;
    tick();
    check_idle("stop", 1'b0);
    stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("stop_hold", 1'b0);
    end

    half_high = 16'd1;
    half_low  = 16'd1;
    duration  = 16'd1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check_idle("stop_prio", 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    end_idle("stop_prio_after");

    begin_note(1, 3, 2);
    for (int i = 0; i < 4; i++) tick();
    check_state("rst_pre", state, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_rst", 1'b0);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("rst_release", 1'b0);
    end

    half_high = 16'd1;
    half_low  = 16'd2;
    duration  = 16'd1;
    start = 1'b1;
    tick();
    half_high = 16'd2;
    half_low  = 16'd0;
    duration  = 16'd2;
    run_note(1, 2, 1, "b2b_first");
    tick();
    start = 1'b0;
    scramble();
    run_note(2, 0, 2, "b2b_second");
    end_idle("b2b_after");

    begin_note(0, 0, 1);
    run_note(0, 0, 1, "zero_high");
    end_idle("zero_high_after");

    for (int n = 0; n < 25; n++) begin
      int hh;
      int hl;
      int dur;
      hh  = int'($urandom_range(0, 4));
      hl  = int'($urandom_range(0, 4));
      dur = int'($urandom_range(0, 3));
      begin_note(hh, hl, dur);
      run_note(hh, hl, dur, "rand");
      if ($urandom_range(0, 1) == 1) end_idle("rand_gap");
    end
    end_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
